// File: rtl/maze_pkg.sv
// Shared move codes, heading encoding and FSM states for the wall-following maze explorer.
package maze_pkg;

    typedef enum logic [2:0] {
        MvStop    = 3'd0,
        MvForward = 3'd1,
        MvLeft    = 3'd2,
        MvRight   = 3'd3,
        MvUTurn   = 3'd4
    } move_e;

    // Row grows southward, col grows eastward.
    typedef enum logic [1:0] {
        HdN = 2'd0,
        HdE = 2'd1,
        HdS = 2'd2,
        HdW = 2'd3
    } heading_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StExplore = 2'd1,
        StDone    = 2'd2
    } state_e;

    function automatic heading_e rotate(input heading_e h, input move_e m);
        heading_e r;
        r = h;
        case (m)
            MvLeft:  r = heading_e'(h - 2'd1);
            MvRight: r = heading_e'(h + 2'd1);
            MvUTurn: r = heading_e'(h + 2'd2);
            default: r = h;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/maze_pos_tracker.sv
// Heading and cell tracker: rotates then advances one cell per enabled command, clamping at
// the grid edges. at_exit_o looks ahead at the cell this command lands on.
module maze_pos_tracker
    import maze_pkg::*;
#(
    parameter int unsigned ROWS      = 9,
    parameter int unsigned COLS      = 9,
    parameter int unsigned START_ROW = 4,
    parameter int unsigned START_COL = 0,
    parameter int unsigned START_DIR = 1,
    parameter int unsigned EXIT_ROW  = 4,
    parameter int unsigned EXIT_COL  = 8,
    localparam int unsigned RW       = $clog2(ROWS),
    localparam int unsigned CW       = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_i,
    input  move_e         command_i,
    output heading_e      heading_o,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          at_exit_o
);

    localparam logic [RW-1:0] RowMax = RW'(ROWS - 1);
    localparam logic [CW-1:0] ColMax = CW'(COLS - 1);

    heading_e      heading_q, heading_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        heading_d = heading_q;
        row_d     = row_q;
        col_d     = col_q;
        if (enable_i && (command_i != MvStop)) begin
            heading_d = rotate(heading_q, command_i);
            unique case (heading_d)
                HdN: if (row_q != '0)     row_d = row_q - RW'(1);
                HdS: if (row_q != RowMax) row_d = row_q + RW'(1);
                HdE: if (col_q != ColMax) col_d = col_q + CW'(1);
                HdW: if (col_q != '0)     col_d = col_q - CW'(1);
            endcase
        end
        at_exit_o = (row_d == RW'(EXIT_ROW)) && (col_d == CW'(EXIT_COL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            heading_q <= heading_e'(START_DIR[1:0]);
            row_q     <= RW'(START_ROW);
            col_q     <= CW'(START_COL);
        end else begin
            heading_q <= heading_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    assign heading_o = heading_q;
    assign row_o     = row_q;
    assign col_o     = col_q;

endmodule

// File: rtl/maze_wall_explorer.sv
// Wall-following maze explorer (IDLE -> EXPLORE -> DONE). Define MAZE_DEADEND_CNT_EN to add
// the saturating dead-end (U-turn) counter and its deadend_cnt port.
module maze_wall_explorer
    import maze_pkg::*;
#(
    parameter int unsigned ROWS      = 9,
    parameter int unsigned COLS      = 9,
    parameter int unsigned START_ROW = 4,
    parameter int unsigned START_COL = 0,
    parameter int unsigned START_DIR = 1,
    parameter int unsigned EXIT_ROW  = 4,
    parameter int unsigned EXIT_COL  = 8,
    parameter int unsigned HAND      = 0,
    parameter int unsigned MAX_STEPS = 255,
    parameter int unsigned DE_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    left,
    input  logic                    mid,
    input  logic                    right,
    output logic [2:0]              move,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    done,
    output logic                    timeout
`ifdef MAZE_DEADEND_CNT_EN
    ,
    output logic [DE_W-1:0]         deadend_cnt
`endif
);

    localparam int unsigned SW = $clog2(MAX_STEPS + 1);

    state_e        state_q, state_d;
    move_e         move_q, move_d;
    move_e         cmd;
    logic          track_en;
    logic          at_exit;
    logic [SW-1:0] step_q, step_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    heading_e      heading;

    // Wall-follow priority: preferred hand, then straight, then the other hand, then back out.
    always_comb begin
        cmd = MvUTurn;
        if (HAND == 0) begin
            if (!left)       cmd = MvLeft;
            else if (!mid)   cmd = MvForward;
            else if (!right) cmd = MvRight;
        end else begin
            if (!right)      cmd = MvRight;
            else if (!mid)   cmd = MvForward;
            else if (!left)  cmd = MvLeft;
        end
    end

    always_comb begin
        state_d   = state_q;
        move_d    = MvStop;
        step_d    = step_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        track_en  = 1'b0;
        case (state_q)
            StIdle: state_d = StExplore;
            StExplore: begin
                track_en = 1'b1;
                move_d   = cmd;
                step_d   = step_q + SW'(1);
                // Exit takes precedence over an exhausted budget on the same step.
                if (at_exit) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (step_d == SW'(MAX_STEPS)) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            move_q    <= MvStop;
            step_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            move_q    <= move_d;
            step_q    <= step_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    maze_pos_tracker #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .START_ROW (START_ROW),
        .START_COL (START_COL),
        .START_DIR (START_DIR),
        .EXIT_ROW  (EXIT_ROW),
        .EXIT_COL  (EXIT_COL)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (track_en),
        .command_i (cmd),
        .heading_o (heading),
        .row_o     (row),
        .col_o     (col),
        .at_exit_o (at_exit)
    );

`ifdef MAZE_DEADEND_CNT_EN
    logic [DE_W-1:0] dead_q, dead_d;

    always_comb begin
        dead_d = dead_q;
        if (track_en && (cmd == MvUTurn) && (dead_q != '1)) dead_d = dead_q + DE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dead_q <= '0;
        else        dead_q <= dead_d;
    end

    assign deadend_cnt = dead_q;
`endif

    logic unused_heading;
    assign unused_heading = ^heading;

    assign move    = move_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_maze_wall_explorer.sv
// Directed bench: vector table on a default explorer, then hand sequences on HAND=1,
// MAX_STEPS=10 and MAX_STEPS=8 instances sharing clock and reset.
module tb_maze_wall_explorer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       l0, m0, r0, d0, t0, lr, mr, rr, dr, tr;
    logic       lt, mt, rt, dt, tt, le, me, re, dd, te;
    logic [2:0] mv0, mvr, mvt, mve;
    logic [3:0] row0, col0, rowr, colr, rowt, colt, rowe, cole;
    logic [7:0] de0, der, det, dee;

    maze_wall_explorer u_dut (
        .clk(clk), .rst_n(rst_n), .left(l0), .mid(m0), .right(r0), .move(mv0),
        .row(row0), .col(col0), .done(d0), .timeout(t0)
`ifdef MAZE_DEADEND_CNT_EN
        , .deadend_cnt(de0)
`endif
    );

    maze_wall_explorer #(.HAND(1)) u_dut_r (
        .clk(clk), .rst_n(rst_n), .left(lr), .mid(mr), .right(rr), .move(mvr),
        .row(rowr), .col(colr), .done(dr), .timeout(tr)
`ifdef MAZE_DEADEND_CNT_EN
        , .deadend_cnt(der)
`endif
    );

    maze_wall_explorer #(.MAX_STEPS(10)) u_dut_t (
        .clk(clk), .rst_n(rst_n), .left(lt), .mid(mt), .right(rt), .move(mvt),
        .row(rowt), .col(colt), .done(dt), .timeout(tt)
`ifdef MAZE_DEADEND_CNT_EN
        , .deadend_cnt(det)
`endif
    );

    maze_wall_explorer #(.MAX_STEPS(8)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .left(le), .mid(me), .right(re), .move(mve),
        .row(rowe), .col(cole), .done(dd), .timeout(te)
`ifdef MAZE_DEADEND_CNT_EN
        , .deadend_cnt(dee)
`endif
    );

    typedef struct {
        logic rst;
        logic l, m, r;
        int   mv, row, col, dn, to, de;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic l, input logic m, input logic r,
                                input int mv, input int row, input int col, input int dn,
                                input int de);
        vec_t v;
        v.rst = rst; v.l = l; v.m = m; v.r = r;
        v.mv = mv; v.row = row; v.col = col; v.dn = dn; v.to = 0; v.de = de;
        return v;
    endfunction

    vec_t vt[25];
    int   t_row[10] = '{3, 3, 4, 4, 3, 3, 4, 4, 3, 3};
    int   t_col[10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    initial begin
        de0 = '0; der = '0; det = '0; dee = '0;
        rst_n = 1'b0;
        {l0, m0, r0, lr, mr, rr, lt, mt, rt, le, me, re} = '0;

        // Left-hand walk in open space, then the straight run to the exit.
        vt[0]  = mk(0, 0, 0, 0, 0, 4, 0, 0, 0);
        vt[1]  = mk(1, 0, 0, 0, 0, 4, 0, 0, 0);
        vt[2]  = mk(1, 0, 0, 0, 2, 3, 0, 0, 0);
        vt[3]  = mk(1, 0, 0, 0, 2, 3, 0, 0, 0);
        vt[4]  = mk(1, 0, 0, 0, 2, 4, 0, 0, 0);
        vt[5]  = mk(1, 0, 0, 0, 2, 4, 1, 0, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 4, 0, 0, 0);
        vt[7]  = mk(1, 1, 0, 1, 0, 4, 0, 0, 0);
        for (int k = 1; k <= 8; k++) vt[7+k] = mk(1, 1, 0, 1, 1, 4, k, (k == 8) ? 1 : 0, 0);
        vt[16] = mk(1, 0, 0, 0, 0, 4, 8, 1, 0);
        vt[17] = mk(1, 1, 1, 1, 0, 4, 8, 1, 0);
        // Reset from DONE, then dead ends and the right/left fallbacks.
        vt[18] = mk(0, 0, 0, 0, 0, 4, 0, 0, 0);
        vt[19] = mk(1, 1, 1, 1, 0, 4, 0, 0, 0);
        vt[20] = mk(1, 1, 1, 1, 4, 4, 0, 0, 1);
        vt[21] = mk(1, 1, 1, 1, 4, 4, 1, 0, 2);
        vt[22] = mk(1, 1, 1, 1, 4, 4, 0, 0, 3);
        vt[23] = mk(1, 1, 1, 0, 3, 3, 0, 0, 3);
        vt[24] = mk(1, 0, 0, 1, 2, 3, 0, 0, 3);

        for (int i = 0; i < 25; i++) begin
            rst_n = vt[i].rst;
            l0 = vt[i].l; m0 = vt[i].m; r0 = vt[i].r;
            step();
            chk($sformatf("v%0d.move", i), int'(mv0), vt[i].mv);
            chk($sformatf("v%0d.row", i), int'(row0), vt[i].row);
            chk($sformatf("v%0d.col", i), int'(col0), vt[i].col);
            chk($sformatf("v%0d.done", i), int'(d0), vt[i].dn);
            chk($sformatf("v%0d.timeout", i), int'(t0), vt[i].to);
`ifdef MAZE_DEADEND_CNT_EN
            chk($sformatf("v%0d.deadend", i), int'(de0), vt[i].de);
`endif
        end

        // Secondary instances: right-hand rule, timeout, exit on the last budgeted step.
        rst_n = 1'b0;
        {lr, mr, rr, lt, mt, rt, le, me, re} = '0;
        step();
        chk("rst.r.row", int'(rowr), 4);
        chk("rst.t.move", int'(mvt), 0);
        chk("rst.e.col", int'(cole), 0);
        rst_n = 1'b1;
        {le, me, re} = 3'b101;
        step();
        chk("idle.r.move", int'(mvr), 0);
        chk("idle.t.move", int'(mvt), 0);
        chk("idle.e.col", int'(cole), 0);

        for (int k = 1; k <= 12; k++) begin
            {lr, mr, rr} = (k == 1) ? 3'b000 : 3'b101;
            step();
            chk($sformatf("r%0d.move", k), int'(mvr), (k == 1) ? 3 : 1);
            chk($sformatf("r%0d.row", k), int'(rowr), (k >= 4) ? 8 : 4 + k);
            chk($sformatf("r%0d.col", k), int'(colr), 0);
            chk($sformatf("r%0d.done", k), int'(dr), 0);

            chk($sformatf("t%0d.move", k), int'(mvt), (k <= 10) ? 2 : 0);
            chk($sformatf("t%0d.timeout", k), int'(tt), (k >= 10) ? 1 : 0);
            chk($sformatf("t%0d.done", k), int'(dt), 0);
            chk($sformatf("t%0d.row", k), int'(rowt), (k <= 10) ? t_row[k-1] : 3);
            chk($sformatf("t%0d.col", k), int'(colt), (k <= 10) ? t_col[k-1] : 0);

            chk($sformatf("e%0d.move", k), int'(mve), (k <= 8) ? 1 : 0);
            chk($sformatf("e%0d.col", k), int'(cole), (k <= 8) ? k : 8);
            chk($sformatf("e%0d.done", k), int'(dd), (k >= 8) ? 1 : 0);
            chk($sformatf("e%0d.timeout", k), int'(te), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
